// File: rtl/dmem_mmio.sv
// Data-memory subsystem: word RAM plus MMIO page (console TX FIFO, cycle counter, halt flag).
// Loads are combinational; all state updates on posedge clk with synchronous active-high reset.
// Optional build macro DMEM_MISALIGN_CHECK_EN: suppresses misaligned RAM stores, raises the
// sticky misaligned flag and treats misaligned MMIO addresses as unmapped.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic        misaligned
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FullCount = (PW + 1)'(FIFO_DEPTH);

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          overflow_q, overflow_d;
  logic          halt_q, halt_d;

  logic ram_sel, mmio_page, ram_wr_en;
  logic tx_sel, status_sel, cycle_sel, halt_sel;
  logic empty, full, pop, push_req, push, status_clr;

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d, misalign_set;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^address[1:0];
`endif

  // Address decode and FIFO handshake terms
  always_comb begin
    ram_sel   = (address[31:AW+2] == '0);
`ifdef DMEM_MISALIGN_CHECK_EN
    mmio_page    = (address[31:4] == 28'hFFFF000) && (address[1:0] == 2'b00);
    ram_wr_en    = we && ram_sel && (address[1:0] == 2'b00);
    misalign_set = we && ram_sel && (address[1:0] != 2'b00);
`else
    mmio_page = (address[31:4] == 28'hFFFF000);
    ram_wr_en = we && ram_sel;
`endif
    tx_sel     = mmio_page && (address[3:2] == 2'd0);
    status_sel = mmio_page && (address[3:2] == 2'd1);
    cycle_sel  = mmio_page && (address[3:2] == 2'd2);
    halt_sel   = mmio_page && (address[3:2] == 2'd3);
    empty      = (count_q == '0);
    full       = (count_q == FullCount);
    pop        = !empty && tx_ready;
    push_req   = we && tx_sel;
    // A full FIFO still takes a byte when the head leaves in the same cycle
    push       = push_req && (!full || pop);
    status_clr = we && status_sel;
  end

  // Next-state for FIFO pointers/count and the MMIO registers
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
    // Clear beats a same-cycle set
    overflow_d = status_clr ? 1'b0 : (overflow_q || (push_req && !push));
    cycle_d    = (we && cycle_sel) ? wdata : cycle_q + 32'd1;
    halt_d     = halt_q || (we && halt_sel);
`ifdef DMEM_MISALIGN_CHECK_EN
    misaligned_d = status_clr ? 1'b0 : (misaligned_q || misalign_set);
`endif
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      overflow_q <= overflow_d;
      halt_q     <= halt_d;
`ifdef DMEM_MISALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  // Storage arrays: not cleared by reset
  always_ff @(posedge clk) begin
    if (ram_wr_en) ram[address[AW+1:2]] <= wdata;
    if (push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  // Combinational load path and output drive
  always_comb begin
    rdata = '0;
    if (ram_sel) begin
      rdata = ram[address[AW+1:2]];
    end else if (mmio_page) begin
      unique case (address[3:2])
        2'd0: rdata = '0;
        2'd1: rdata = {28'b0, misaligned, overflow_q, full, empty};
        2'd2: rdata = cycle_q;
        2'd3: rdata = {31'b0, halt_q};
      endcase
    end
    tx_valid = !empty;
    tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr_q];
    halt     = halt_q;
`ifdef DMEM_MISALIGN_CHECK_EN
    misaligned = misaligned_q;
`else
    misaligned = 1'b0;
`endif
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: queue/array reference model compared every cycle,
// plus directed literal expectations following the test plan.
module tb_dmem_mmio;

  localparam int unsigned RamWords  = 1024;
  localparam int unsigned FifoDepth = 8;
  localparam logic [31:0] TxA  = 32'hFFFF_0000;
  localparam logic [31:0] StA  = 32'hFFFF_0004;
  localparam logic [31:0] CycA = 32'hFFFF_0008;
  localparam logic [31:0] HltA = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        halt;
  logic        misaligned;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_mmio #(.RAM_WORDS(RamWords), .FIFO_DEPTH(FifoDepth)) dut (
    .clk(clk), .reset(reset), .we(we), .address(address), .wdata(wdata), .rdata(rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .halt(halt),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mram [int unsigned];
  logic [7:0]  fq [$];
  bit          m_ovf, m_mis, m_halt, model_ok;
  logic [31:0] m_cyc;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_ram(input logic [31:0] a);
    return longint'(a) < longint'(RamWords) * 4;
  endfunction

  // Returns MMIO register number 0..3, or -1 if the address is not a mapped register
  function automatic int mmio_reg(input logic [31:0] a);
    if (a < TxA || a > TxA + 32'd15) return -1;
    if (ChkEn && (a % 4 != 0)) return -1;
    return int'((a - TxA) / 4);
  endfunction

  function automatic bit exp_rdata(input logic [31:0] a, output logic [31:0] v);
    v = '0;
    if (in_ram(a)) begin
      if (!mram.exists(a / 4)) return 1'b0;
      v = mram[a / 4];
      return 1'b1;
    end
    case (mmio_reg(a))
      1: v = {28'b0, m_mis, m_ovf, fq.size() == FifoDepth, fq.size() == 0};
      2: v = m_cyc;
      3: v = {31'b0, m_halt};
      default: v = '0;
    endcase
    return 1'b1;
  endfunction

  task automatic model_step();
    int sz;
    bit pop, clr;
    logic [31:0] nc;
    if (reset) begin
      fq.delete();
      m_ovf = 0; m_mis = 0; m_halt = 0; m_cyc = '0; model_ok = 1;
      return;
    end
    sz  = fq.size();
    pop = (sz > 0) && tx_ready;
    nc  = m_cyc + 1;
    clr = 0;
    if (pop) void'(fq.pop_front());
    if (we) begin
      if (in_ram(address)) begin
        if (ChkEn && (address % 4 != 0)) m_mis = 1;
        else mram[address / 4] = wdata;
      end else begin
        case (mmio_reg(address))
          0: if (sz < FifoDepth || pop) fq.push_back(wdata[7:0]); else m_ovf = 1;
          1: clr = 1;
          2: nc = wdata;
          3: m_halt = 1;
          default: ;
        endcase
      end
    end
    if (clr) begin m_ovf = 0; m_mis = 0; end
    m_cyc = nc;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [31:0] ev;
    if (model_ok && !reset) begin
      check("tx_valid", {31'b0, tx_valid}, {31'b0, fq.size() > 0});
      if (fq.size() > 0) check("tx_data", {24'b0, tx_data}, {24'b0, fq[0]});
      check("halt", {31'b0, halt}, {31'b0, m_halt});
      check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      if (exp_rdata(address, ev)) check("rdata", rdata, ev);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d, input bit r);
    we = w; address = a; wdata = d; tx_ready = r;
  endtask

  initial begin
    step();
    reset = 1'b0;
    drive(0, CycA, 0, 0); #1;
    check("lit_cycle_after_reset", rdata, 32'h0);
    address = StA; #1;
    check("lit_status_after_reset", rdata, 32'h1);
    check("lit_halt_after_reset", {31'b0, halt}, 32'h0);
    step();

    // RAM store/load, old data visible in the store cycle
    drive(1, 32'h10, 32'h1111_1111, 0); step();
    drive(1, 32'h10, 32'hDEAD_BEEF, 0); #1;
    check("lit_ram_read_during_write", rdata, 32'h1111_1111);
    step();
    drive(0, 32'h10, 0, 0); #1;
    check("lit_ram_read_after_write", rdata, 32'hDEAD_BEEF);
    step();

    // Unmapped write must not alias into RAM; unmapped reads return 0
    drive(1, 32'h0, 32'h55, 0); step();
    drive(1, 32'h1000, 32'h99, 0); step();
    drive(0, 32'h0, 0, 0); #1;
    check("lit_unmapped_no_alias", rdata, 32'h55);
    address = 32'hFFFF_0010; #1;
    check("lit_unmapped_read", rdata, 32'h0);
    step();

    // Fill FIFO with ready low, then overflow
    for (int i = 0; i < 8; i++) begin
      drive(1, TxA, 32'h41 + i, 0);
      if (i == 0) begin #1; check("lit_no_bypass", {31'b0, tx_valid}, 32'h0); end
      step();
    end
    drive(0, StA, 0, 0); #1;
    check("lit_status_full", rdata, 32'h2);
    drive(1, TxA, 32'h49, 0); step();
    drive(0, StA, 0, 0); #1;
    check("lit_status_overflow", rdata, 32'h6);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(0, StA, 0, 1); #1;
      check("lit_drain_byte", {24'b0, tx_data}, 32'h41 + i);
      step();
    end
    drive(0, StA, 0, 0); #1;
    check("lit_status_drained", rdata, 32'h5);
    drive(1, StA, 0, 0); step();
    drive(0, StA, 0, 0); #1;
    check("lit_status_cleared", rdata, 32'h1);

    // Full FIFO, push with simultaneous pop
    for (int i = 0; i < 8; i++) begin drive(1, TxA, 32'h50 + i, 0); step(); end
    drive(1, TxA, 32'h58, 1); step();
    drive(0, StA, 0, 0); #1;
    check("lit_full_push_pop_status", rdata, 32'h2);
    check("lit_full_push_pop_head", {24'b0, tx_data}, 32'h51);
    for (int i = 0; i < 8; i++) begin drive(0, StA, 0, 1); step(); end
    drive(0, StA, 0, 0); #1;
    check("lit_status_empty_again", rdata, 32'h1);

    // Cycle counter load and wrap
    drive(1, CycA, 32'hFFFF_FFFE, 0); step();
    drive(0, CycA, 0, 0); #1;
    check("lit_cycle_loaded", rdata, 32'hFFFF_FFFE);
    step(); check("lit_cycle_max", rdata, 32'hFFFF_FFFF);
    step(); check("lit_cycle_wrap", rdata, 32'h0);

    // Halt is sticky until reset
    drive(1, HltA, 0, 0); step();
    drive(0, HltA, 0, 0); #1;
    check("lit_halt_set", {31'b0, halt}, 32'h1);
    check("lit_halt_read", rdata, 32'h1);
    step(); step();
    check("lit_halt_sticky", {31'b0, halt}, 32'h1);
    reset = 1'b1; step();
    reset = 1'b0;
    drive(0, CycA, 0, 0); #1;
    check("lit_halt_cleared", {31'b0, halt}, 32'h0);
    check("lit_cycle_reset", rdata, 32'h0);
    address = StA; #1;
    check("lit_status_reset", rdata, 32'h1);
    step();

    // Misaligned store
    drive(1, 32'h20, 32'hAAAA_AAAA, 0); step();
    drive(1, 32'h22, 32'h1234_5678, 0); step();
    drive(0, 32'h20, 0, 0); #1;
`ifdef DMEM_MISALIGN_CHECK_EN
    check("lit_misalign_suppressed", rdata, 32'hAAAA_AAAA);
    check("lit_misalign_flag", {31'b0, misaligned}, 32'h1);
    address = StA; #1;
    check("lit_misalign_status", rdata, 32'h9);
`else
    check("lit_misalign_written", rdata, 32'h1234_5678);
    check("lit_misalign_flag", {31'b0, misaligned}, 32'h0);
    address = StA; #1;
    check("lit_misalign_status", rdata, 32'h1);
`endif
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
